// File: rtl/hilo_fwd_file.sv
// hilo_fwd_file: HI/LO special-register file with read forwarding and a mul/div scoreboard.
// Latency: hi_o/lo_o are combinational from fwd_*/wb_*; a commit is visible from the register one cycle after the write-back edge.
// Backpressure: issue_ready drops at MAX_PENDING ops in flight; hilo_busy stalls readers while any op is pending.
//
// Optional feature macro: HILO_WB_BYPASS_EN
//   defined   -> write-back data is a forwarding source (below all fwd slots, above the register)
//   undefined -> reads see the stored register only; a write-back value appears the cycle after commit
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   fwd_hi_we/fwd_lo_we         per-slot write enables (slot 0 youngest)
//   fwd_hi_i/fwd_lo_i           per-slot data, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wb_hi_we/wb_lo_we           write-back commit enables
//   wb_hi_i/wb_lo_i             write-back commit data
//   md_issue/md_done            multi-cycle op accepted / result produced
//   flush                       cancels all pending ops
//   hi_o/lo_o                   forwarded HI/LO
//   hilo_busy, issue_ready      scoreboard status (combinational from the count register)
//   pending_cnt                 ops in flight
//   sb_err                      sticky scoreboard over/underflow flag
module hilo_fwd_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_FWD     = 2,
  parameter int MAX_PENDING = 3,
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_FWD-1:0]            fwd_hi_we,
  input  logic [NUM_FWD-1:0]            fwd_lo_we,
  input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_hi_i,
  input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_lo_i,
  input  logic                          wb_hi_we,
  input  logic                          wb_lo_we,
  input  logic [DATA_WIDTH-1:0]         wb_hi_i,
  input  logic [DATA_WIDTH-1:0]         wb_lo_i,
  input  logic                          md_issue,
  input  logic                          md_done,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         hi_o,
  output logic [DATA_WIDTH-1:0]         lo_o,
  output logic                          hilo_busy,
  output logic                          issue_ready,
  output logic [CNT_W-1:0]              pending_cnt,
  output logic                          sb_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  // --------------------------------------------------------------------
  // Architectural registers
  // --------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_hi_we) hi_d = wb_hi_i;
    if (wb_lo_we) lo_d = wb_lo_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // --------------------------------------------------------------------
  // Read forwarding. HI and LO are resolved independently so that e.g.
  // mthi in MEM and mtlo in WB both forward in the same cycle.
  // The slot scan runs oldest to youngest so the lowest-index (youngest)
  // enabled slot is the last assignment and therefore wins.
  // --------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] hi_base;
  logic [DATA_WIDTH-1:0] lo_base;
  logic [DATA_WIDTH-1:0] hi_sel;
  logic [DATA_WIDTH-1:0] lo_sel;

`ifdef HILO_WB_BYPASS_EN
  // Write-back sits between the fwd slots and the register, so a reader in
  // the same cycle as the commit sees the committing value.
  always_comb begin
    hi_base = wb_hi_we ? wb_hi_i : hi_q;
    lo_base = wb_lo_we ? wb_lo_i : lo_q;
  end
`else
  // Write-back is not a source; the pipeline must place WB among the fwd
  // slots or stall one cycle if it needs the committing value.
  always_comb begin
    hi_base = hi_q;
    lo_base = lo_q;
  end
`endif

  always_comb begin
    hi_sel = hi_base;
    lo_sel = lo_base;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_hi_we[k]) hi_sel = fwd_hi_i[k*DATA_WIDTH +: DATA_WIDTH];
      if (fwd_lo_we[k]) lo_sel = fwd_lo_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign hi_o = hi_sel;
  assign lo_o = lo_sel;

  // --------------------------------------------------------------------
  // Multiply/divide scoreboard
  // --------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             can_issue;
  logic             can_retire;

  assign can_issue  = (cnt_q < MAX_CNT);
  assign can_retire = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (flush) begin
      // Flush cancels everything in flight, including any same-cycle
      // issue or done; the error flag is deliberately left untouched.
      cnt_d = '0;
    end else if (md_issue && md_done) begin
      // One op retires while another enters: occupancy is unchanged.
      cnt_d = cnt_q;
    end else if (md_issue) begin
      if (can_issue) cnt_d = cnt_q + ONE_CNT;
      else           err_d = 1'b1;
    end else if (md_done) begin
      if (can_retire) cnt_d = cnt_q - ONE_CNT;
      else            err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign pending_cnt = cnt_q;
  assign hilo_busy   = can_retire;
  assign issue_ready = can_issue;
  assign sb_err      = err_q;

endmodule

// File: tb/tb_hilo_fwd_file.sv
// tb_hilo_fwd_file: directed-vector bench for hilo_fwd_file (DATA_WIDTH=32, NUM_FWD=2, MAX_PENDING=3).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled before the next edge.
// Expected values are hand-computed constants; the write-back bypass expectation follows HILO_WB_BYPASS_EN.
module tb_hilo_fwd_file;

  logic        clk;
  logic        rst_n;
  logic [1:0]  fwd_hi_we;
  logic [1:0]  fwd_lo_we;
  logic [63:0] fwd_hi_i;
  logic [63:0] fwd_lo_i;
  logic        wb_hi_we;
  logic        wb_lo_we;
  logic [31:0] wb_hi_i;
  logic [31:0] wb_lo_i;
  logic        md_issue;
  logic        md_done;
  logic        flush;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        hilo_busy;
  logic        issue_ready;
  logic [1:0]  pending_cnt;
  logic        sb_err;

  int n_vec;
  int n_err;

  hilo_fwd_file #(
    .DATA_WIDTH (32),
    .NUM_FWD    (2),
    .MAX_PENDING(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fwd_hi_we  (fwd_hi_we),
    .fwd_lo_we  (fwd_lo_we),
    .fwd_hi_i   (fwd_hi_i),
    .fwd_lo_i   (fwd_lo_i),
    .wb_hi_we   (wb_hi_we),
    .wb_lo_we   (wb_lo_we),
    .wb_hi_i    (wb_hi_i),
    .wb_lo_i    (wb_lo_i),
    .md_issue   (md_issue),
    .md_done    (md_done),
    .flush      (flush),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .hilo_busy  (hilo_busy),
    .issue_ready(issue_ready),
    .pending_cnt(pending_cnt),
    .sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fwd_hi_we = '0;
    fwd_lo_we = '0;
    fwd_hi_i  = '0;
    fwd_lo_i  = '0;
    wb_hi_we  = 1'b0;
    wb_lo_we  = 1'b0;
    wb_hi_i   = '0;
    wb_lo_i   = '0;
    md_issue  = 1'b0;
    md_done   = 1'b0;
    flush     = 1'b0;
  endtask

  logic [1:0] exp_cnt [4];
  logic       exp_rdy [4];
  logic       exp_err [4];
  logic [31:0] exp_same;

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_err = '{1'b0, 1'b0, 1'b0, 1'b1};

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk("rst_hi",    hi_o, 32'h0);
    chk("rst_lo",    lo_o, 32'h0);
    chk("rst_busy",  {31'b0, hilo_busy}, 32'd0);
    chk("rst_ready", {31'b0, issue_ready}, 32'd1);
    chk("rst_cnt",   {30'b0, pending_cnt}, 32'd0);
    chk("rst_err",   {31'b0, sb_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- forwarding priority ----------------
    fwd_hi_we = 2'b11;
    fwd_lo_we = 2'b10;
    fwd_hi_i  = {32'h22222222, 32'h11111111};
    fwd_lo_i  = {32'h33333333, 32'h44444444};
    #1;
    chk("fwd_hi_slot0_wins", hi_o, 32'h11111111);
    chk("fwd_lo_slot1",      lo_o, 32'h33333333);
    fwd_hi_we = 2'b10;
    fwd_lo_we = 2'b01;
    #1;
    chk("fwd_hi_slot1_only", hi_o, 32'h22222222);
    chk("fwd_lo_slot0_only", lo_o, 32'h44444444);
    idle_inputs();
    #1;
    chk("fwd_off_hi", hi_o, 32'h0);

    // ---------------- write-back commit / bypass ----------------
    tick();
    wb_hi_we = 1'b1;
    wb_hi_i  = 32'hDEADBEEF;
`ifdef HILO_WB_BYPASS_EN
    exp_same = 32'hDEADBEEF;
`else
    exp_same = 32'h0;
`endif
    #1;
    chk("wb_same_cycle_hi", hi_o, exp_same);
    chk("wb_same_cycle_lo", lo_o, 32'h0);
    // A fwd slot beats write-back regardless of the bypass build.
    fwd_hi_we = 2'b10;
    fwd_hi_i  = {32'h55555555, 32'h0};
    #1;
    chk("fwd_over_wb", hi_o, 32'h55555555);
    tick();
    idle_inputs();
    #1;
    chk("wb_committed_hi", hi_o, 32'hDEADBEEF);
    chk("wb_lo_held",      lo_o, 32'h0);
    wb_lo_we = 1'b1;
    wb_lo_i  = 32'h0BADF00D;
    tick();
    idle_inputs();
    #1;
    chk("wb_committed_lo", lo_o, 32'h0BADF00D);
    chk("hi_held",         hi_o, 32'hDEADBEEF);

    // ---------------- issue to saturation ----------------
    for (int i = 0; i < 4; i++) begin
      md_issue = 1'b1;
      tick();
      md_issue = 1'b0;
      chk($sformatf("issue%0d_cnt", i),   {30'b0, pending_cnt}, {30'b0, exp_cnt[i]});
      chk($sformatf("issue%0d_ready", i), {31'b0, issue_ready}, {31'b0, exp_rdy[i]});
      chk($sformatf("issue%0d_err", i),   {31'b0, sb_err},      {31'b0, exp_err[i]});
      chk($sformatf("issue%0d_busy", i),  {31'b0, hilo_busy},   32'd1);
    end

    // done brings it to 2, then issue+done together holds at 2
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("done_cnt", {30'b0, pending_cnt}, 32'd2);
    md_issue = 1'b1;
    md_done  = 1'b1;
    tick();
    md_issue = 1'b0;
    md_done  = 1'b0;
    chk("iss_done_cnt", {30'b0, pending_cnt}, 32'd2);

    // flush wins over a same-cycle issue; sb_err stays set
    flush    = 1'b1;
    md_issue = 1'b1;
    tick();
    flush    = 1'b0;
    md_issue = 1'b0;
    chk("flush_cnt",   {30'b0, pending_cnt}, 32'd0);
    chk("flush_busy",  {31'b0, hilo_busy},   32'd0);
    chk("flush_ready", {31'b0, issue_ready}, 32'd1);
    chk("flush_err",   {31'b0, sb_err},      32'd1);

    // ---------------- async reset mid-stream ----------------
    wb_hi_we = 1'b1;
    wb_hi_i  = 32'hCAFEF00D;
    md_issue = 1'b1;
    tick();
    idle_inputs();
    chk("pre_rst_hi",  hi_o, 32'hCAFEF00D);
    chk("pre_rst_cnt", {30'b0, pending_cnt}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hi",  hi_o, 32'h0);
    chk("async_rst_lo",  lo_o, 32'h0);
    chk("async_rst_cnt", {30'b0, pending_cnt}, 32'd0);
    chk("async_rst_err", {31'b0, sb_err}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // ---------------- underflow ----------------
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("underflow_cnt", {30'b0, pending_cnt}, 32'd0);
    chk("underflow_err", {31'b0, sb_err}, 32'd1);
    tick();
    chk("err_sticky", {31'b0, sb_err}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
